// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: CRT fetch handshake, CPU byte port and SRAM pins.
// slave = arbiter side, master = requesters plus SRAM device side.
interface vram_arbiter_if #(
    parameter int AW = 16
);
    logic [AW-1:0] vad;
    logic          vram_cs;
    logic          vram_complete;
    logic [7:0]    vdo;

    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_di;
    logic          cpu_rw;
    logic          cpu_cs;
    logic          cpu_ready;
    logic [7:0]    cpu_do;

    logic [AW-1:0] sram_a;
    logic [7:0]    sram_dout;
    logic [7:0]    sram_din;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ce_n;

    modport slave (
        input  vad, vram_cs, cpu_addr, cpu_di, cpu_rw, cpu_cs, sram_din,
        output vram_complete, vdo, cpu_ready, cpu_do,
               sram_a, sram_dout, sram_oe_n, sram_we_n, sram_ce_n
    );

    modport master (
        output vad, vram_cs, cpu_addr, cpu_di, cpu_rw, cpu_cs, sram_din,
        input  vram_complete, vdo, cpu_ready, cpu_do,
               sram_a, sram_dout, sram_oe_n, sram_we_n, sram_ce_n
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port SRAM arbiter: CRT video fetch (priority) and CPU byte port.
// Optional macro VRAM_ARB_FAIR_EN: alternate grants when both ports contend.
module vram_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int AW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_cnt;
    logic          r_owner_cpu;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_dout;
    logic [7:0]    r_vdo;
    logic [7:0]    r_cpu_do;
    logic          r_varm;
    logic          r_carm;

    logic          w_vpend;
    logic          w_cpend;
    logic          w_grant_v;
    logic          w_grant_c;
    logic          w_rd;
    logic          w_ce_n;
    logic          w_oe_n;
    logic          w_we_n;
    logic          w_vcomp;
    logic          w_cready;

    assign w_vpend = bus.vram_cs && r_varm;
    assign w_cpend = bus.cpu_cs && r_carm;

`ifdef VRAM_ARB_FAIR_EN
    logic r_last_cpu;

    assign w_grant_v = w_vpend && (!w_cpend || r_last_cpu);
    assign w_grant_c = w_cpend && (!w_vpend || !r_last_cpu);
`else
    assign w_grant_v = w_vpend;
    assign w_grant_c = w_cpend && !w_vpend;
`endif

    assign w_rd = !r_owner_cpu || r_rw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ce_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_vcomp     = 1'b0;
        w_cready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_v || w_grant_c) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_ce_n = 1'b0;
                if (w_rd) begin
                    w_oe_n = 1'b0;
                end else if (r_cnt != 3'd0 || WAIT_STATES == 0) begin
                    // last write cycle is a data hold with we_n high
                    w_we_n = 1'b0;
                end
                if (r_cnt == 3'd0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_vcomp     = !r_owner_cpu;
                w_cready    = r_owner_cpu;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_owner_cpu <= 1'b0;
            r_rw        <= 1'b1;
            r_addr      <= '0;
            r_dout      <= '0;
            r_vdo       <= '0;
            r_cpu_do    <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_grant_v) begin
                    r_addr      <= bus.vad;
                    r_owner_cpu <= 1'b0;
                    r_rw        <= 1'b1;
                    r_cnt       <= LP_WAIT;
                end else if (w_grant_c) begin
                    r_addr      <= bus.cpu_addr;
                    r_dout      <= bus.cpu_di;
                    r_owner_cpu <= 1'b1;
                    r_rw        <= bus.cpu_rw;
                    r_cnt       <= LP_WAIT;
                end
            end
            if (r_state == ACCESS) begin
                if (r_cnt != 3'd0) begin
                    r_cnt <= r_cnt - 3'd1;
                end else if (!r_owner_cpu) begin
                    r_vdo <= bus.sram_din;
                end else if (r_rw) begin
                    r_cpu_do <= bus.sram_din;
                end
            end
        end
    end

    // A low cs sample re-arms the port, even in its own completion cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_varm <= 1'b1;
            r_carm <= 1'b1;
        end else begin
            if (!bus.vram_cs) begin
                r_varm <= 1'b1;
            end else if (w_vcomp) begin
                r_varm <= 1'b0;
            end
            if (!bus.cpu_cs) begin
                r_carm <= 1'b1;
            end else if (w_cready) begin
                r_carm <= 1'b0;
            end
        end
    end

`ifdef VRAM_ARB_FAIR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_cpu <= 1'b1;
        end else if (r_state == IDLE && (w_grant_v || w_grant_c)) begin
            r_last_cpu <= w_grant_c;
        end
    end
`endif

    assign bus.sram_a        = r_addr;
    assign bus.sram_dout     = r_dout;
    assign bus.sram_ce_n     = w_ce_n;
    assign bus.sram_oe_n     = w_oe_n;
    assign bus.sram_we_n     = w_we_n;
    assign bus.vram_complete = w_vcomp;
    assign bus.cpu_ready     = w_cready;
    assign bus.vdo           = r_vdo;
    assign bus.cpu_do        = r_cpu_do;
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// serial traffic checked against a reference memory and latency rules.
module tb_vram_arbiter;
    localparam int W1 = 1;
    localparam int EXP_LAT = W1 + 2;
    localparam int EXP_WE = (W1 == 0) ? 1 : W1;
    localparam int EXP_OE = W1 + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] exp_cpu_do;

    vram_arbiter_if #(.AW(16)) b1 ();
    vram_arbiter_if #(.AW(16)) b0 ();

    vram_arbiter #(.WAIT_STATES(W1), .AW(16)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    vram_arbiter #(.WAIT_STATES(0),  .AW(16)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    // Asynchronous SRAM models
    assign b1.sram_din = (!b1.sram_ce_n && !b1.sram_oe_n) ? mem[b1.sram_a] : 8'h00;
    assign b0.sram_din = (!b0.sram_ce_n && !b0.sram_oe_n) ? 8'h5A : 8'h00;

    always @(posedge clk) begin
        if (!b1.sram_ce_n && !b1.sram_we_n) mem[b1.sram_a] = b1.sram_dout;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic vid_read(input logic [15:0] a, input int hold, output logic [7:0] d,
                            output int lat, output int oe_lo, output logic [15:0] aseen);
        @(negedge clk);
        b1.vad = a; b1.vram_cs = 1'b1;
        lat = 0; oe_lo = 0; d = '0; aseen = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (!b1.sram_oe_n) oe_lo++;
            if (lat == 1) begin aseen = b1.sram_a; b1.vad = 16'($urandom); end
            if (b1.vram_complete) begin d = b1.vdo; break; end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("vid_no_reserve", 32'(b1.sram_ce_n), 32'd1);
        end
        b1.vram_cs = 1'b0;
    endtask

    task automatic cpu_op(input logic rw, input logic [15:0] a, input logic [7:0] di,
                          output logic [7:0] d, output int lat, output int oe_lo,
                          output int we_lo, output logic [7:0] dseen, output logic [15:0] aseen);
        @(negedge clk);
        b1.cpu_addr = a; b1.cpu_di = di; b1.cpu_rw = rw; b1.cpu_cs = 1'b1;
        lat = 0; oe_lo = 0; we_lo = 0; d = '0; dseen = '0; aseen = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (!b1.sram_oe_n) oe_lo++;
            if (!b1.sram_we_n) begin we_lo++; dseen = b1.sram_dout; end
            if (lat == 1) begin
                aseen = b1.sram_a;
                b1.cpu_addr = 16'($urandom); b1.cpu_di = 8'($urandom); b1.cpu_rw = ~rw;
            end
            if (b1.cpu_ready) begin d = b1.cpu_do; break; end
        end
        b1.cpu_cs = 1'b0;
    endtask

    // Both ports request continuously; video either drops cs on its pulse
    // (eager) or one cycle later (lazy). Records owner of first 4 grants.
    task automatic contend(input bit lazy_v, output logic [3:0] ord, output int gap);
        int n = 0;
        int t = 0;
        int t0 = 0;
        bit v_re = 1'b0;
        bit v_drop = 1'b0;
        bit c_re = 1'b0;
        @(negedge clk);
        b1.vad = 16'h0040; b1.cpu_addr = 16'h0040; b1.cpu_rw = 1'b1;
        b1.vram_cs = 1'b1; b1.cpu_cs = 1'b1;
        ord = '0; gap = -1;
        while (n < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (v_re) begin b1.vram_cs = 1'b1; v_re = 1'b0; end
            if (v_drop) begin b1.vram_cs = 1'b0; v_drop = 1'b0; v_re = 1'b1; end
            if (c_re) begin b1.cpu_cs = 1'b1; c_re = 1'b0; end
            if (b1.vram_complete || b1.cpu_ready) begin
                if (n == 1) gap = t - t0;
                t0 = t;
                ord = ord | (4'(b1.cpu_ready) << n);
                n++;
            end
            if (b1.vram_complete) begin
                if (lazy_v) v_drop = 1'b1;
                else begin b1.vram_cs = 1'b0; v_re = 1'b1; end
            end
            if (b1.cpu_ready) begin b1.cpu_cs = 1'b0; c_re = 1'b1; end
        end
        b1.vram_cs = 1'b0; b1.cpu_cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [7:0]  dseen;
        logic [15:0] aseen;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [3:0]  ord;
        int lat, oe_lo, we_lo, gap, kind, t, t1, t2, nrdy, nwe;
        bit reraise;

        b1.vad = '0; b1.vram_cs = 1'b0; b1.cpu_addr = '0; b1.cpu_di = '0;
        b1.cpu_rw = 1'b1; b1.cpu_cs = 1'b0;
        b0.vad = '0; b0.vram_cs = 1'b0; b0.cpu_addr = '0; b0.cpu_di = '0;
        b0.cpu_rw = 1'b1; b0.cpu_cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + 16'(i)] = 8'($urandom);
            ref_mem[16'h0100 + 16'(i)] = mem[16'h0100 + 16'(i)];
        end
        mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
        mem[16'h0040] = 8'h00; ref_mem[16'h0040] = 8'h00;
        mem[16'h0050] = 8'h11; ref_mem[16'h0050] = 8'h11;
        exp_cpu_do = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_complete", 32'(b1.vram_complete), 32'd0);
        chk("rst_ready", 32'(b1.cpu_ready), 32'd0);
        chk("rst_vdo", 32'(b1.vdo), 32'h00);
        chk("rst_cpu_do", 32'(b1.cpu_do), 32'h00);
        chk("rst_strobes", {29'd0, b1.sram_ce_n, b1.sram_oe_n, b1.sram_we_n}, 32'h7);
        chk("rst_sram_a", 32'(b1.sram_a), 32'h0);
        chk("rst_sram_dout", 32'(b1.sram_dout), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Video read of 0x1234, cs held high after completion
        vid_read(16'h1234, 3, rd, lat, oe_lo, aseen);
        chk("v1_addr", 32'(aseen), 32'h1234);
        chk("v1_oe_cycles", 32'(oe_lo), 32'(EXP_OE));
        chk("v1_latency", 32'(lat), 32'(EXP_LAT));
        chk("v1_vdo", 32'(rd), 32'hA5);

        // CPU write then read back
        cpu_op(1'b0, 16'h0040, 8'h3C, rd, lat, oe_lo, we_lo, dseen, aseen);
        ref_mem[16'h0040] = 8'h3C;
        chk("cw_addr", 32'(aseen), 32'h0040);
        chk("cw_we_cycles", 32'(we_lo), 32'(EXP_WE));
        chk("cw_dout", 32'(dseen), 32'h3C);
        chk("cw_latency", 32'(lat), 32'(EXP_LAT));
        chk("cw_cpu_do_held", 32'(b1.cpu_do), 32'(exp_cpu_do));
        cpu_op(1'b1, 16'h0040, 8'h00, rd, lat, oe_lo, we_lo, dseen, aseen);
        exp_cpu_do = 8'h3C;
        chk("cr_cpu_do", 32'(rd), 32'h3C);
        chk("cr_oe_cycles", 32'(oe_lo), 32'(EXP_OE));
        chk("cr_no_we", 32'(we_lo), 32'd0);

        // Contention: lazy video yields alternate grants in either build
        contend(1'b1, ord, gap);
        chk("lazy_order", 32'(ord), 32'b1010);
        chk("lazy_gap", 32'(gap), 32'(W1 + 3));
        contend(1'b0, ord, gap);
`ifdef VRAM_ARB_FAIR_EN
        chk("eager_order", 32'(ord), 32'b1010);
`else
        chk("eager_order", 32'(ord), 32'b0000);
`endif
        chk("eager_gap", 32'(gap), 32'(W1 + 3));
        chk("cont_cpu_do", 32'(b1.cpu_do), 32'(exp_cpu_do));

        // WAIT_STATES=0 instance: latency 2, back-to-back spacing 3
        @(negedge clk);
        b0.vad = 16'h0777; b0.vram_cs = 1'b1;
        t = 0; t1 = -1; t2 = -1; reraise = 1'b0; rd = '0; aseen = '0;
        while (t < 30 && t2 < 0) begin
            @(negedge clk);
            t++;
            if (t == 1) aseen = b0.sram_a;
            if (reraise) begin b0.vram_cs = 1'b1; reraise = 1'b0; end
            if (b0.vram_complete) begin
                if (t1 < 0) begin t1 = t; rd = b0.vdo; end
                else t2 = t;
                b0.vram_cs = 1'b0; reraise = 1'b1;
            end
        end
        b0.vram_cs = 1'b0;
        chk("w0_addr", 32'(aseen), 32'h0777);
        chk("w0_latency", 32'(t1), 32'd2);
        chk("w0_gap", 32'(t2 - t1), 32'd3);
        chk("w0_vdo", 32'(rd), 32'h5A);

        // Reset during a CPU write access
        @(negedge clk);
        b1.cpu_addr = 16'h0050; b1.cpu_di = 8'h77; b1.cpu_rw = 1'b0; b1.cpu_cs = 1'b1;
        @(negedge clk);
        chk("rw_we_low", {30'd0, b1.sram_we_n, b1.sram_ce_n}, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("rw_async_strobes", {30'd0, b1.sram_we_n, b1.sram_ce_n}, 32'h3);
        nrdy = 0;
        repeat (3) begin
            @(negedge clk);
            if (b1.cpu_ready) nrdy++;
        end
        chk("rw_no_ready_in_rst", 32'(nrdy), 32'd0);
        chk("rw_mem_untouched", 32'(mem[16'h0050]), 32'h11);
        rst = 1'b1;
        exp_cpu_do = 8'h00;
        nrdy = 0; nwe = 0;
        repeat (20) begin
            @(negedge clk);
            if (b1.cpu_ready) nrdy++;
            if (!b1.sram_we_n) nwe++;
        end
        b1.cpu_cs = 1'b0;
        ref_mem[16'h0050] = 8'h77;
        chk("rw_reexec_ready", 32'(nrdy), 32'd1);
        chk("rw_reexec_we", 32'(nwe), 32'(EXP_WE));
        chk("rw_cpu_do_reset", 32'(b1.cpu_do), 32'h00);
        cpu_op(1'b1, 16'h0050, 8'h00, rd, lat, oe_lo, we_lo, dseen, aseen);
        exp_cpu_do = ref_mem[16'h0050];
        chk("rw_readback", 32'(rd), 32'(exp_cpu_do));

        // Randomized serial traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            a = 16'h0100 + 16'($urandom_range(0, 15));
            wd = 8'($urandom);
            if (kind == 0) begin
                vid_read(a, 0, rd, lat, oe_lo, aseen);
                chk("rnd_vid_data", 32'(rd), 32'(ref_mem[a]));
            end else if (kind == 1) begin
                cpu_op(1'b1, a, wd, rd, lat, oe_lo, we_lo, dseen, aseen);
                exp_cpu_do = ref_mem[a];
                chk("rnd_cpu_rd", 32'(rd), 32'(ref_mem[a]));
            end else begin
                cpu_op(1'b0, a, wd, rd, lat, oe_lo, we_lo, dseen, aseen);
                ref_mem[a] = wd;
                chk("rnd_cpu_we", 32'(we_lo), 32'(EXP_WE));
                chk("rnd_cpu_dout", 32'(dseen), 32'(wd));
            end
            chk("rnd_addr", 32'(aseen), 32'(a));
            chk("rnd_latency", 32'(lat), 32'(EXP_LAT));
            chk("rnd_cpu_do_held", 32'(b1.cpu_do), 32'(exp_cpu_do));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
